// File: rtl/mdu.sv
// Purpose: MIPS multiply/divide unit holding HI/LO; mult/multu/div/divu are multi-cycle, mthi/mtlo are single-edge.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES busy cycles with HI/LO written on the completion edge; mthi/mtlo visible after the issue edge.
// Backpressure: none; start while busy is dropped, so control must stall HI/LO users while busy is high.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start, mdop     issue strobe and op code (0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op)
//   rs_data/rt_data operand A (dividend/multiplicand/mthi-mtlo source) and operand B
//   busy, hi, lo    registered status and HI/LO registers
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  op_q;

  // Result datapath is combinational over the latched operands; it only
  // needs to be valid on the completion edge.
  logic        is_signed;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_b;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] quo;
  logic [31:0] rem;

  assign is_signed = ~op_q[0];

  // Sign/zero extension to 64 bits makes the truncated 64-bit product
  // correct for both signed and unsigned multiplies.
  assign ext_a = {{32{is_signed & a_q[31]}}, a_q};
  assign ext_b = {{32{is_signed & b_q[31]}}, b_q};
  assign prod  = ext_a * ext_b;

  // Signed divide via magnitudes: quotient truncates toward zero and the
  // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 without special casing.
  assign neg_a = is_signed & a_q[31];
  assign neg_b = is_signed & b_q[31];
  assign mag_a = neg_a ? -a_q : a_q;
  assign mag_b = neg_b ? -b_q : b_q;
  // Guard the divider against zero; a zero-divisor result is never written.
  assign div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign q_u   = mag_a / div_b;
  assign r_u   = mag_a % div_b;
  assign quo   = (neg_a ^ neg_b) ? -q_u : q_u;
  assign rem   = neg_a ? -r_u : r_u;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      cnt   <= 32'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      op_q  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (mdop)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                a_q   <= rs_data;
                b_q   <= rt_data;
                op_q  <= mdop[1:0];
                cnt   <= mdop[1] ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
                state <= RUN;
                busy  <= 1'b1;
              end
              3'd4: hi <= rs_data;
              3'd5: lo <= rs_data;
              default: ;
            endcase
          end
        end
        RUN: begin
          // start is deliberately not looked at here, including on the
          // completion edge.
          if (cnt == 32'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 32'd0;
            if (!op_q[1]) begin
              hi <= prod[63:32];
              lo <= prod[31:0];
            end else if (b_q != 32'd0) begin
              hi <= rem;
              lo <= quo;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int vecs = 0;
  int errs = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mdop    (mdop),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven and outputs
  // sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    mdop    = op;
    rs_data = a;
    rt_data = b;
    tick();
    start   = 1'b0;
    rs_data = 32'hA5A5_A5A5;
    rt_data = 32'h5A5A_5A5A;
  endtask

  // Issue, require busy for exactly n cycles with HI/LO holding, then
  // check the result right after the completion edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] old_hi,
                        input logic [31:0] old_lo, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    issue(op, a, b);
    for (int i = 0; i < n; i++) begin
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      if (i == n - 1) begin
        check({tag, " hi hold"}, hi, old_hi);
        check({tag, " lo hold"}, lo, old_lo);
      end
      tick();
    end
    check({tag, " busy done"}, {31'd0, busy}, 32'd0);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    mdop    = 3'd0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    tick();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b0;
    tick();

    run_op("mult -2*3", 3'd0, 32'hFFFF_FFFE, 32'd3, 5,
           32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu max*max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 10,
           32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 7/-2", 3'd2, 32'd7, 32'hFFFF_FFFE, 10,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001, 32'hFFFF_FFFD);

    // mthi/mtlo then divide by zero
    issue(3'd4, 32'h0000_1234, 32'd0);
    check("mthi hi", hi, 32'h0000_1234);
    check("mthi busy", {31'd0, busy}, 32'd0);
    issue(3'd5, 32'h0000_5678, 32'd0);
    check("mtlo lo", lo, 32'h0000_5678);
    check("mtlo hi", hi, 32'h0000_1234);
    run_op("divu 7/0", 3'd3, 32'd7, 32'd0, 10,
           32'h0000_1234, 32'h0000_5678, 32'h0000_1234, 32'h0000_5678);

    // mdop 6 is a no-op
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    check("nop busy", {31'd0, busy}, 32'd0);
    check("nop hi", hi, 32'h0000_1234);
    check("nop lo", lo, 32'h0000_5678);

    // mtlo during cycle 2 of a mult is ignored
    issue(3'd0, 32'd6, 32'd7);
    tick();
    start   = 1'b1;
    mdop    = 3'd5;
    rs_data = 32'hDEAD_0000;
    tick();
    start   = 1'b0;
    check("mtlo-in-run lo", lo, 32'h0000_5678);
    check("mtlo-in-run busy", {31'd0, busy}, 32'd1);
    tick();
    tick();
    tick();
    check("mult 6*7 busy done", {31'd0, busy}, 32'd0);
    check("mult 6*7 hi", hi, 32'd0);
    check("mult 6*7 lo", lo, 32'd42);

    // reset during cycle 3 of a div
    issue(3'd2, 32'd100, 32'd7);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid reset busy", {31'd0, busy}, 32'd0);
    check("mid reset hi", hi, 32'd0);
    check("mid reset lo", lo, 32'd0);
    repeat (12) tick();
    check("no late write busy", {31'd0, busy}, 32'd0);
    check("no late write hi", hi, 32'd0);
    check("no late write lo", lo, 32'd0);

    // Overflow divide, then re-issue at completion edge and one later
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (9) tick();
    check("ovf busy last", {31'd0, busy}, 32'd1);
    start   = 1'b1;
    mdop    = 3'd2;
    rs_data = 32'd100;
    rt_data = 32'd7;
    tick();
    check("ovf busy done", {31'd0, busy}, 32'd0);
    check("ovf hi", hi, 32'd0);
    check("ovf lo", lo, 32'h8000_0000);
    tick();
    start   = 1'b0;
    check("reissue accepted busy", {31'd0, busy}, 32'd1);
    begin
      int waited = 0;
      while (busy === 1'b1 && waited < 50) begin
        tick();
        waited++;
      end
      check("reissue cycles", 32'(waited), 32'd10);
    end
    check("reissue hi", hi, 32'd2);
    check("reissue lo", lo, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
